// File: rtl/idle_sync_fsm.sv
// idle_sync_fsm: receive-side link-state controller ahead of the recirculation demux.
// Hunts for a run of COMMA bytes (SEARCH), waits for payload (SYNC), and forwards
// payload (ACTIVE) until LOSS_NEEDED consecutive non-payload cycles are seen.
// IDLE_OUT = 1 makes the demux recirculate; 0 lets payload through to the lanes.
// Optional build macro SEARCH_ERR_CNT_EN adds err_cnt, a saturating count of
// partial comma runs broken by an idle or payload byte while in SEARCH.
module idle_sync_fsm #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR   = 8'h7C,
  parameter int unsigned BC_NEEDED   = 4,
  parameter int unsigned LOSS_NEEDED = 3
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       IDLE_OUT,
  output logic       active_out,
  output logic [1:0] state_out,
  output logic [2:0] comma_cnt
`ifdef SEARCH_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [2:0] BC_LIM   = 3'(BC_NEEDED);
  localparam logic [2:0] LOSS_LIM = 3'(LOSS_NEEDED);

  state_e     state_q, state_d;
  logic [2:0] comma_q, comma_d;
  logic [2:0] loss_q,  loss_d;
  logic       idle_q,  idle_d;
  logic       active_q, active_d;

  logic       is_comma, is_idle, is_payload;
  logic [2:0] comma_inc, loss_inc;

  assign is_comma   = valid_in && (data_in == COMMA);
  assign is_idle    = valid_in && (data_in == IDLE_CHAR);
  assign is_payload = valid_in && !is_comma && !is_idle;
  assign comma_inc  = comma_q + 3'd1;
  assign loss_inc   = loss_q + 3'd1;

  // Next-state and counter update; counters are cleared on every transition.
  always_comb begin
    state_d = state_q;
    comma_d = comma_q;
    loss_d  = loss_q;
    unique case (state_q)
      SEARCH: begin
        if (is_comma) begin
          if (comma_inc == BC_LIM) begin
            state_d = SYNC;
            comma_d = '0;
          end else begin
            comma_d = comma_inc;
          end
        end else if (valid_in) begin
          comma_d = '0;
        end
      end
      SYNC: begin
        if (is_payload) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (is_payload) begin
          loss_d = '0;
        end else if (loss_inc == LOSS_LIM) begin
          state_d = SYNC;
          loss_d  = '0;
        end else begin
          loss_d = loss_inc;
        end
      end
      default: begin
        state_d = SEARCH;
        comma_d = '0;
        loss_d  = '0;
      end
    endcase
    // Outputs are decoded from the next state so they update on the same edge
    // that samples the byte, then held in flops.
    idle_d   = (state_d != ACTIVE);
    active_d = (state_d == ACTIVE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      comma_q  <= '0;
      loss_q   <= '0;
      idle_q   <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      comma_q  <= comma_d;
      loss_q   <= loss_d;
      idle_q   <= idle_d;
      active_q <= active_d;
    end
  end

  assign IDLE_OUT   = idle_q;
  assign active_out = active_q;
  assign state_out  = state_q;
  assign comma_cnt  = comma_q;

`ifdef SEARCH_ERR_CNT_EN
  logic [7:0] err_q, err_d;

  // Count broken partial comma runs in SEARCH, saturating at all-ones.
  always_comb begin
    err_d = err_q;
    if ((state_q == SEARCH) && valid_in && !is_comma && (comma_q != '0) && (err_q != '1)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
